keystroke_queue: RTL and testbench



---
 rtl/keystroke_queue.sv | 121 ++++++++++++
 tb/tb_keystroke_queue.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/keystroke_queue.sv
// PS/2 set-2 keystroke filter feeding a FIFO of ASCII codes for the draw FSM.
// Break/extended/modifier/unmapped codes are dropped; accepted make codes are queued.
module keystroke_queue #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        scan_code,
  input  logic              scan_code_ready,
  input  logic [6:0]        ascii_in,
  input  logic              pop,
  output logic [6:0]        char_out,
  output logic              char_valid,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    F_IDLE    = 2'd0,
    F_BRK     = 2'd1,
    F_EXT     = 2'd2,
    F_EXT_BRK = 2'd3
  } filt_e;

  filt_e              filt_q, filt_d;
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [6:0]         char_out_q, char_out_d;
  logic               char_valid_q, char_valid_d;
  logic               overflow_q, overflow_d;
  logic [6:0]         mem_q [DEPTH];

  logic push_req_c;
  logic push_ok_c;
  logic pop_ok_c;

  // Scan-code filter: only plain make codes with a mapped ASCII value request a push.
  always_comb begin
    filt_d     = filt_q;
    push_req_c = 1'b0;
    if (scan_code_ready) begin
      case (filt_q)
        F_IDLE: begin
          if (scan_code == 8'hF0) begin
            filt_d = F_BRK;
          end else if (scan_code == 8'hE0) begin
            filt_d = F_EXT;
          end else if (scan_code != 8'h12 && scan_code != 8'h59) begin
            push_req_c = (ascii_in != 7'h00);
          end
        end
        F_BRK:     filt_d = F_IDLE;
        F_EXT:     filt_d = (scan_code == 8'hF0) ? F_EXT_BRK : F_IDLE;
        F_EXT_BRK: filt_d = F_IDLE;
        default:   filt_d = F_IDLE;
      endcase
    end
  end

  // FIFO bookkeeping; a pop on a full queue frees the slot for a same-cycle push.
  always_comb begin
    pop_ok_c     = pop && (count_q != '0);
    push_ok_c    = push_req_c && ((count_q != DEPTH_C) || pop_ok_c);
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q | (push_req_c & ~push_ok_c);
    if (push_ok_c) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop_ok_c)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({push_ok_c, pop_ok_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Head after the edge: the incoming code bypasses memory when it lands at the head.
    char_out_d   = char_out_q;
    char_valid_d = (count_d != '0);
    if (count_d != '0) begin
      if (push_ok_c && (wr_ptr_q == rd_ptr_d)) char_out_d = ascii_in;
      else                                      char_out_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      filt_q       <= F_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      char_out_q   <= 7'h00;
      char_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      filt_q       <= filt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      char_out_q   <= char_out_d;
      char_valid_q <= char_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage is not reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (reset_n && push_ok_c) mem_q[wr_ptr_q] <= ascii_in;
  end

  assign char_out   = char_out_q;
  assign char_valid = char_valid_q;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign full       = (count_q == DEPTH_C);

endmodule

// File: tb/tb_keystroke_queue.sv
// Directed bench for keystroke_queue: filter rules, FIFO order, full/overflow, reset.
module tb_keystroke_queue;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] scan_code;
  logic       scan_code_ready;
  logic [6:0] ascii_in;
  logic       pop;
  logic [6:0] char_out;
  logic       char_valid;
  logic       full;
  logic [4:0] count;
  logic       overflow;

  int n_cmp = 0;
  int n_err = 0;

  keystroke_queue #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .scan_code       (scan_code),
    .scan_code_ready (scan_code_ready),
    .ascii_in        (ascii_in),
    .pop             (pop),
    .char_out        (char_out),
    .char_valid      (char_valid),
    .full            (full),
    .count           (count),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] code, input logic [6:0] asc);
    scan_code       = code;
    ascii_in        = asc;
    scan_code_ready = 1'b1;
    tick();
    scan_code_ready = 1'b0;
    ascii_in        = 7'h00;
  endtask

  task automatic do_pop();
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; scan_code = 8'h00; scan_code_ready = 1'b0; ascii_in = 7'h00; pop = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(char_valid), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_char", 32'(char_out), 32'h00);

    // Single make code, then pop
    strobe(8'h1C, 7'h61);
    chk("one_valid", 32'(char_valid), 32'd1);
    chk("one_char", 32'(char_out), 32'h61);
    chk("one_count", 32'(count), 32'd1);
    do_pop();
    chk("pop_valid", 32'(char_valid), 32'd0);
    chk("pop_count", 32'(count), 32'd0);
    chk("pop_hold_char", 32'(char_out), 32'h61);
    do_pop();
    chk("pop_empty_count", 32'(count), 32'd0);
    chk("pop_empty_valid", 32'(char_valid), 32'd0);

    // Make, break, released key: one character
    strobe(8'h1C, 7'h61);
    strobe(8'hF0, 7'h00);
    strobe(8'h1C, 7'h61);
    chk("brk_count", 32'(count), 32'd1);
    chk("brk_char", 32'(char_out), 32'h61);
    do_pop();
    chk("brk_drain", 32'(count), 32'd0);

    // Extended, extended break, shift, shift break, unmapped: nothing queued
    strobe(8'hE0, 7'h00); strobe(8'h75, 7'h38);
    strobe(8'hE0, 7'h00); strobe(8'hF0, 7'h00); strobe(8'h75, 7'h38);
    strobe(8'h12, 7'h53); strobe(8'hF0, 7'h00); strobe(8'h12, 7'h53);
    strobe(8'h59, 7'h53);
    strobe(8'h0E, 7'h00);
    chk("filt_count", 32'(count), 32'd0);
    chk("filt_valid", 32'(char_valid), 32'd0);
    strobe(8'h1C, 7'h62);
    chk("filt_idle_char", 32'(char_out), 32'h62);
    do_pop();

    // 17 codes into 16 slots
    for (int i = 0; i < 17; i++) strobe(8'h1C, 7'(7'h41 + i));
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    chk("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk("ovf_order", 32'(char_out), 32'(7'h41 + i));
      do_pop();
    end
    chk("ovf_drain_valid", 32'(char_valid), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_drain_full", 32'(full), 32'd0);

    // Full queue with simultaneous push and pop
    do_reset();
    chk("ovf_cleared", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) strobe(8'h1C, 7'(7'h41 + i));
    chk("pp_full", 32'(full), 32'd1);
    scan_code = 8'h1C; ascii_in = 7'h5A; scan_code_ready = 1'b1; pop = 1'b1;
    tick();
    scan_code_ready = 1'b0; ascii_in = 7'h00; pop = 1'b0;
    chk("pp_count", 32'(count), 32'd16);
    chk("pp_ovf", 32'(overflow), 32'd0);
    chk("pp_head", 32'(char_out), 32'h42);
    for (int i = 0; i < 15; i++) begin
      chk("pp_order", 32'(char_out), 32'(7'h42 + i));
      do_pop();
    end
    chk("pp_tail", 32'(char_out), 32'h5A);
    chk("pp_tail_count", 32'(count), 32'd1);

    // One entry, push and pop together
    scan_code = 8'h1C; ascii_in = 7'h7A; scan_code_ready = 1'b1; pop = 1'b1;
    tick();
    scan_code_ready = 1'b0; ascii_in = 7'h00; pop = 1'b0;
    chk("pp1_valid", 32'(char_valid), 32'd1);
    chk("pp1_char", 32'(char_out), 32'h7A);
    chk("pp1_count", 32'(count), 32'd1);
    do_pop();
    chk("pp1_drain", 32'(char_valid), 32'd0);

    // Reset dominates a coincident strobe and pop
    strobe(8'h1C, 7'h61); strobe(8'h1C, 7'h62); strobe(8'h1C, 7'h63);
    chk("pre_rst_count", 32'(count), 32'd3);
    reset_n = 1'b0; scan_code = 8'hF0; ascii_in = 7'h00; scan_code_ready = 1'b1; pop = 1'b1;
    tick();
    reset_n = 1'b1; scan_code_ready = 1'b0; pop = 1'b0;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_valid", 32'(char_valid), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    chk("mid_rst_char", 32'(char_out), 32'h00);
    strobe(8'h1C, 7'h61);
    chk("post_rst_count", 32'(count), 32'd1);
    chk("post_rst_char", 32'(char_out), 32'h61);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
